rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream resource (e.g. an encoder or bus port) among `WIDTH` requesters. It selects a single owner with a rotating-priority lowest-set-bit search and holds the grant until the owner signals completion. A watchdog revokes grants that never complete. It sits between the requester array and the resource, and drives the resource's select/valid.

---
 rtl/rr_arbiter_pkg.sv | 11 +
 rtl/rr_arb_pick.sv | 41 ++++
 rtl/rr_arbiter.sv | 119 +++++++++++
 tb/tb_rr_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_pkg.sv
// rtl/rr_arbiter_pkg.sv - shared types for the round-robin arbiter
// Purpose: state encoding used by rr_arbiter.
// Ports: none (package).
package rr_arbiter_pkg;

  typedef enum logic {
    IDLE_S  = 1'b0,
    GRANT_S = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb_pick.sv
// rtl/rr_arb_pick.sv - combinational rotating-priority lowest-set-bit search
// Purpose: picks the lowest requester at or above ptr, else the lowest overall.
// Ports:
//   req  in  WIDTH   request vector
//   ptr  in  IW      highest-priority index
//   gnt  out WIDTH   one-hot winner (zero when no request)
//   id   out IW      binary index of the winner
//   any  out 1       at least one request present
module rr_arb_pick #(
  parameter int WIDTH = 16,
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [WIDTH-1:0] gnt,
  output logic [IW-1:0]    id,
  output logic             any
);

  logic [WIDTH-1:0] one;
  logic [WIDTH-1:0] lo_mask;
  logic [WIDTH-1:0] masked;
  logic [WIDTH-1:0] src;

  assign one = {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    // Bits below ptr lose priority this round.
    lo_mask = (one << ptr) - one;
    masked  = req & ~lo_mask;
    src     = (|masked) ? masked : req;
    // Two's-complement trick isolates the lowest set bit.
    gnt     = src & (~src + one);
    id      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (gnt[i]) id = IW'(i);
    end
    any     = |req;
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with grant hold and watchdog
// Purpose: grants one of WIDTH requesters, holds until done_i, revokes
//   grants held TIMEOUT cycles without done_i.
// Optional feature macro: RR_ARB_LOCK_EN adds lock_i (owner keeps grant
//   across done_i).
// Ports:
//   clk_i      in  1      clock, rising edge
//   rst_n_i    in  1      asynchronous active-low reset
//   req_i      in  WIDTH  level requests
//   done_i     in  1      owner transaction complete
//   lock_i     in  1      owner keeps grant (RR_ARB_LOCK_EN only)
//   gnt_o      out WIDTH  one-hot grant
//   gnt_id_o   out IW     owner index
//   gnt_val_o  out 1      grant active
//   timeout_o  out 1      one-cycle watchdog revoke pulse
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [WIDTH-1:0]         req_i,
  input  logic                     done_i,
`ifdef RR_ARB_LOCK_EN
  input  logic                     lock_i,
`endif
  output logic [WIDTH-1:0]         gnt_o,
  output logic [$clog2(WIDTH)-1:0] gnt_id_o,
  output logic                     gnt_val_o,
  output logic                     timeout_o
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t           state;
  logic [IW-1:0]    ptr;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    nxt_ptr;
  logic [IW-1:0]    pick_ptr;
  logic [WIDTH-1:0] p_gnt;
  logic [IW-1:0]    p_id;
  logic             p_any;
  logic             expire;
  logic             lock_eff;

`ifdef RR_ARB_LOCK_EN
  assign lock_eff = lock_i;
`else
  assign lock_eff = 1'b0;
`endif

  assign nxt_ptr  = (gnt_id_o == IW'(WIDTH - 1)) ? '0 : gnt_id_o + IW'(1);
  // While granting, a release re-picks with the post-release pointer so the
  // new owner lands on the same edge.
  assign pick_ptr = (state == GRANT_S) ? nxt_ptr : ptr;
  assign expire   = (cnt == CW'(TIMEOUT - 1));

  rr_arb_pick #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_pick (
    .req (req_i),
    .ptr (pick_ptr),
    .gnt (p_gnt),
    .id  (p_id),
    .any (p_any)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE_S;
      ptr       <= '0;
      cnt       <= '0;
      gnt_o     <= '0;
      gnt_id_o  <= '0;
      gnt_val_o <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        IDLE_S: begin
          if (p_any) begin
            gnt_o     <= p_gnt;
            gnt_id_o  <= p_id;
            gnt_val_o <= 1'b1;
            cnt       <= '0;
            state     <= GRANT_S;
          end
        end
        GRANT_S: begin
          if (done_i && lock_eff) begin
            cnt <= '0;
          end else if (done_i || expire) begin
            // A real done_i outranks a coincident expiry: no pulse then.
            timeout_o <= ~done_i;
            ptr       <= nxt_ptr;
            cnt       <= '0;
            if (p_any) begin
              gnt_o    <= p_gnt;
              gnt_id_o <= p_id;
            end else begin
              gnt_o     <= '0;
              gnt_id_o  <= '0;
              gnt_val_o <= 1'b0;
              state     <= IDLE_S;
            end
          end else if (cnt != {CW{1'b1}}) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE_S;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - self-checking bench for rr_arbiter
module tb_rr_arbiter;

  localparam int W  = 16;
  localparam int TO = 4;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  req;
  logic          done;
  logic          lock;
  logic [W-1:0]  gnt;
  logic [3:0]    gnt_id;
  logic          gnt_val;
  logic          timeout;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: owner index, whether a grant is live, pointer,
  // and how many cycles the current grant has been visible.
  int m_ptr, m_own, m_held;
  bit m_val, m_to;

  rr_arbiter #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .req_i     (req),
    .done_i    (done),
`ifdef RR_ARB_LOCK_EN
    .lock_i    (lock),
`endif
    .gnt_o     (gnt),
    .gnt_id_o  (gnt_id),
    .gnt_val_o (gnt_val),
    .timeout_o (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scan upward from p with wraparound; first requester found wins.
  function automatic int pick(input logic [W-1:0] r, input int p);
    for (int k = 0; k < W; k++) begin
      if (r[(p + k) % W]) return (p + k) % W;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_own = 0; m_held = 0; m_val = 0; m_to = 0;
  endtask

  task automatic model_edge(input logic [W-1:0] r, input bit d, input bit l);
    int  w;
    bit  exp_now;
    bit  l_eff;
`ifdef RR_ARB_LOCK_EN
    l_eff = l;
`else
    l_eff = 1'b0;
`endif
    m_to = 0;
    if (!m_val) begin
      w = pick(r, m_ptr);
      if (w >= 0) begin
        m_own = w; m_val = 1; m_held = 1;
      end
    end else begin
      exp_now = (m_held == TO);
      if (d && l_eff) begin
        m_held = 1;
      end else if (d || exp_now) begin
        m_to  = !d;
        m_ptr = (m_own + 1) % W;
        w     = pick(r, m_ptr);
        if (w >= 0) begin
          m_own = w; m_held = 1;
        end else begin
          m_val = 0;
        end
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [W-1:0] eg;
    eg = m_val ? (W'(1) << m_own) : '0;
    check({tag, ".gnt"}, 32'(gnt), 32'(eg));
    check({tag, ".id"}, 32'(gnt_id), m_val ? 32'(m_own) : 32'd0);
    check({tag, ".val"}, 32'(gnt_val), 32'(m_val));
    check({tag, ".to"}, 32'(timeout), 32'(m_to));
  endtask

  // Drive inputs just after an edge, clock once, sample 1ns after the edge.
  task automatic step(input logic [W-1:0] r, input bit d, input bit l, input string tag);
    req = r; done = d; lock = l;
    @(posedge clk);
    model_edge(r, d, l);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; done = 1'b0; lock = 1'b0;
    model_reset();
    #2;
    compare_all("por");
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) step(16'h0000, 0, 0, "idle");

    step(16'h0014, 0, 0, "tp1");
    check("tp1.gnt_c", 32'(gnt), 32'h0004);
    check("tp1.id_c", 32'(gnt_id), 32'd2);
    step(16'h0014, 1, 0, "tp1d1");
    check("tp1d1.gnt_c", 32'(gnt), 32'h0010);
    step(16'h0014, 1, 0, "tp1d2");
    check("tp1d2.gnt_c", 32'(gnt), 32'h0004);

    do_reset("rst1");
    step(16'h8000, 0, 0, "wrap0");
    step(16'h8001, 1, 0, "wrap1");
    check("wrap.gnt_c", 32'(gnt), 32'h0001);

    do_reset("rst2");
    step(16'h0003, 0, 0, "wd0");
    for (int i = 0; i < TO - 1; i++) step(16'h0003, 0, 0, "wdh");
    step(16'h0003, 0, 0, "wdx");
    check("wd.to_c", 32'(timeout), 32'd1);
    check("wd.gnt_c", 32'(gnt), 32'h0002);
    step(16'h0003, 0, 0, "wdp");
    check("wd.pulse_c", 32'(timeout), 32'd0);

    do_reset("rst3");
    step(16'h0003, 0, 0, "wdd0");
    for (int i = 0; i < TO - 1; i++) step(16'h0003, 0, 0, "wddh");
    step(16'h0003, 1, 0, "wddx");
    check("wdd.to_c", 32'(timeout), 32'd0);
    check("wdd.gnt_c", 32'(gnt), 32'h0002);

    step(16'h00F0, 0, 0, "mid");
    do_reset("rstmid");
    step(16'h0100, 0, 0, "post");
    check("post.id_c", 32'(gnt_id), 32'd8);

`ifdef RR_ARB_LOCK_EN
    do_reset("rst4");
    step(16'h0008, 0, 0, "lk0");
    for (int i = 0; i < 3; i++) step(16'h00F8, 1, 1, "lkh");
    check("lk.id_c", 32'(gnt_id), 32'd3);
    step(16'h00F8, 1, 0, "lkr");
    check("lkr.id_c", 32'(gnt_id), 32'd4);
`endif

    do_reset("rst5");
    for (int i = 0; i < 2000; i++) begin
      logic [W-1:0] r;
      case ($urandom_range(0, 3))
        0: r = '0;
        1: r = W'($urandom);
        2: r = W'($urandom) & W'($urandom) & W'($urandom);
        default: r = W'(1) << $urandom_range(0, W - 1);
      endcase
      step(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
